// File: rtl/ysyx_040066_wb_arbiter.sv
// Writeback stage: one main-pipe stage register and a small long-latency result FIFO share a single rf write port.
// Define YSYX_040066_WB_MISALIGN_EN to raise an exception on misaligned loads/stores.
module ysyx_040066_wb_arbiter #(
  parameter int  XLEN     = 64,
  parameter int  LQ_DEPTH = 2,
  localparam int AW       = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wen,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_memrd,
  input  logic            in_memwr,
  input  logic [2:0]      in_memop,
  input  logic [AW-1:0]   in_addr_low,
  input  logic            in_error,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_error,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            exc_valid
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);

  typedef struct packed {
    logic            wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            memrd;
    logic            memwr;
    logic [2:0]      memop;
    logic [AW-1:0]   addr_low;
    logic            err;
  } stage_t;

  stage_t                         s;
  logic                           s_valid;
  logic [LQ_DEPTH-1:0][4:0]       q_rd;
  logic [LQ_DEPTH-1:0][XLEN-1:0]  q_data;
  logic [PW-1:0]                  head, tail;
  logic [CW-1:0]                  count;
  logic                           accept, push, pop, retire;
  logic                           s_err, mis_trap, writer, full;
  logic [1:0]                     sz;
  logic [AW-1:0]                  lane_mask, lane;
  logic [XLEN-1:0]                shifted, ld_data, s_wdata;
  int                             shamt;

  // Lane select: clearing the size-aligned low bits gives the lane; shifting
  // up then back down truncates to the access size and extends.
  always_comb begin
    sz = s.memop[1:0];
    if (XLEN == 32 && sz == 2'd3) sz = 2'd2;
    lane_mask = (AW'(1) << sz) - AW'(1);
    lane      = s.addr_low & ~lane_mask;
    shifted   = mem_rdata >> {lane, 3'b000};
    shamt     = XLEN - (8 << sz);
    ld_data   = s.memop[2] ? (shifted << shamt) >> shamt
                           : XLEN'($signed(shifted << shamt) >>> shamt);
  end

`ifdef YSYX_040066_WB_MISALIGN_EN
  assign mis_trap = (s.memrd || s.memwr) && |(s.addr_low & lane_mask);
`else
  assign mis_trap = 1'b0;
`endif

  assign s_wdata = s.memrd ? ld_data : s.data;
  assign s_err   = s.err || (mem_error && (s.memrd || s.memwr)) || mis_trap;
  assign writer  = s_valid && s.wen && !s_err && (s.rd != 5'd0);
  assign full    = (count == CW'(LQ_DEPTH));

  always_comb begin
    pop       = 1'b0;
    retire    = 1'b0;
    rf_wen    = 1'b0;
    rf_rd     = 5'd0;
    rf_data   = '0;
    exc_valid = 1'b0;
    if (writer && full) begin
      pop = 1'b1;                     // drain FIFO first so it cannot starve
    end else if (writer) begin
      retire  = 1'b1;
      rf_wen  = 1'b1;
      rf_rd   = s.rd;
      rf_data = s_wdata;
    end else begin
      retire = s_valid;
      pop    = (count != '0);
    end
    if (pop) begin
      rf_wen  = (q_rd[head] != 5'd0);
      rf_rd   = q_rd[head];
      rf_data = q_data[head];
    end
    exc_valid = retire && s_err;
    if (rst) begin
      rf_wen    = 1'b0;
      exc_valid = 1'b0;
    end
  end

  assign in_ready = rst || !s_valid || retire;
  assign ll_ready = rst || (count < CW'(LQ_DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = ll_valid && ll_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      if (accept)      s_valid <= 1'b1;
      else if (retire) s_valid <= 1'b0;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s.wen      <= in_wen;
      s.rd       <= in_rd;
      s.data     <= in_data;
      s.memrd    <= in_memrd;
      s.memwr    <= in_memwr;
      s.memop    <= in_memop;
      s.addr_low <= in_addr_low;
      s.err      <= in_error;
    end
    if (push) begin
      q_rd[tail]   <= ll_rd;
      q_data[tail] <= ll_data;
    end
  end
endmodule
